// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 serial receiver.
// Synchronises the RX pin, qualifies start bits at mid-bit, samples each bit at
// its centre, and holds the received byte in a one-entry valid/ready buffer.
// A framing error or a dropped byte is reported as a one-cycle pulse.
module uart_rx_framer #(
  parameter int CLOCK_FREQ = 10_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  // The timer holds the count of the previous cycle, so a match on N-1 means
  // the line is being looked at exactly N cycles after the reference edge.
  localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, state_nxt;
  logic             sync1, line;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic timer_clr, shift_en, load, fe_nxt, ovr_nxt;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      line  <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    fe_nxt    = 1'b0;
    ovr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!line) begin
          state_nxt = START;
          timer_clr = 1'b1;
        end
      end
      START: begin
        // Mid-point of the start bit: a high line here was only a glitch.
        if (timer == SAMPLE_LAST) begin
          timer_clr = 1'b1;
          state_nxt = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == SYM_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer == SYM_LAST) begin
          if (line) begin
            state_nxt = IDLE;
            // A byte being consumed this cycle frees the slot for the new one.
            if (!data_out_valid || data_out_ready) load = 1'b1;
            else                                   ovr_nxt = 1'b1;
          end else begin
            // Stop bit low: drop the byte and wait out the held-low line.
            state_nxt = BREAK;
            fe_nxt    = 1'b1;
          end
        end
      end
      BREAK: begin
        if (line) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer, bit index and shift register. The timer wraps every bit period
  // so every sample stays locked to the original start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (timer_clr)
        timer <= '0;
      else if (state == START || state == DATA || state == STOP)
        timer <= (timer == SYM_LAST) ? '0 : timer + 1'b1;

      if (state == START && timer_clr)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;

      if (shift_en)
        shreg <= {line, shreg[7:1]};
    end
  end

  // One-entry output buffer and the single-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= fe_nxt;
      overrun       <= ovr_nxt;
      if (load) begin
        data_out       <= shreg;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial receive stage between the registered FPGA_SERIAL_RX pin and the CPU's UART MMIO.
- Synchronises the line and detects start bits, rejecting glitches.
- Samples 8N1 frames at mid-bit and presents each byte through a one-entry valid/ready buffer.
- Reports framing errors and overruns as single-cycle pulses; the CPU latches these into its UART status CSR.

Parameters:
- CLOCK_FREQ, 10_000_000, cpu_clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- SYMBOL_EDGE_TIME (localparam), CLOCK_FREQ / BAUD_RATE (integer divide), cycles per bit; 86 at defaults.
- SAMPLE_TIME (localparam), SYMBOL_EDGE_TIME / 2, mid-bit offset; 43 at defaults.
- CNT_W (localparam), $clog2(SYMBOL_EDGE_TIME), bit-timer width.

Ports:
- clk, input, 1, cpu_clk; all state on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- serial_in, input, 1, RX line; idle high; asynchronous to clk.
- data_out, output, 8, received byte; LSB is the first data bit on the wire.
- data_out_valid, output, 1, data_out holds an unconsumed byte.
- data_out_ready, input, 1, consumer accepts data_out this cycle when valid is also high.
- framing_error, output, 1, one-cycle pulse: stop bit sampled 0.
- overrun, output, 1, one-cycle pulse: a good byte was dropped because the buffer was full.
- rx_busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - Both synchroniser FFs reset to 1.
  - FSM reset to IDLE; bit timer, bit index and shift register reset to 0.
  - data_out resets to 8'h00; data_out_valid, framing_error, overrun and rx_busy reset to 0.
  - Asserting rst mid-frame abandons the frame with no pulse emitted.
- Synchroniser:
  - Two flops on serial_in; "line" below means the second flop's output.
  - Pin-to-line latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On a cycle where line == 0, go to START and clear the timer. Call this edge t0.
- START:
  - The timer increments each cycle.
  - At t0+SAMPLE_TIME the line is sampled:
    - line == 0: go to DATA, clear timer, bit index = 0.
    - line == 1: glitch; return to IDLE with no output.
- DATA:
  - Data bit k (k = 0..7) is sampled at t0 + SAMPLE_TIME + (k+1)*SYMBOL_EDGE_TIME.
  - Each sampled bit is shifted into the MSB and the register shifts right.
  - After bit 7, go to STOP.
- STOP:
  - Stop bit is sampled at t0 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME (call this ts).
  - line == 1, buffer empty, or the buffer is being consumed this cycle (data_out_valid & data_out_ready): data_out <= shift register and data_out_valid = 1 from ts+1. Go to IDLE.
  - line == 1 and buffer full and not consumed this cycle: data_out is unchanged and overrun = 1 for exactly the cycle ts+1. Go to IDLE.
  - line == 0: shift register discarded; framing_error = 1 for exactly cycle ts+1. Go to BREAK.
- BREAK:
  - Wait until line == 1, then go to IDLE.
  - Prevents a held-low line from retriggering frames.
- Output buffer:
  - data_out_valid & data_out_ready clears valid on the next edge, unless a new byte loads on the same edge; then valid stays 1 with the new data.
  - data_out is stable while valid is 1 and no load occurs.
  - data_out_ready is ignored while valid is 0.
- Back-to-back frames:
  - The FSM is in IDLE from ts+1.
  - A start edge arriving while in STOP is not missed: the next frame's falling edge occurs at least SAMPLE_TIME cycles after ts.
- Timer:
  - Counts 0..SYMBOL_EDGE_TIME-1 and then wraps.
  - Sampling occurs on the compare match; no drift accumulates across the 10 bits.

Test Plan (defaults: 86 cycles/bit, 43 sample):
- Byte 8'hA5 sent at 86 cycles/bit, ready held 0 → data_out = 8'hA5 and valid rises exactly at ts+1 = t0+818. Then pulse ready one cycle → valid is 0 on the next cycle.
- Line low for 20 cycles then high → FSM returns to IDLE at t0+43; no valid, no error pulse; the next valid frame 8'h3C is received correctly.
- Frame 8'h55 with stop bit forced 0, held low 2000 cycles → framing_error single pulse at ts+1 and valid stays 0. Then send 8'h81 → received as 8'h81.
- Two frames 8'h11 then 8'h22, ready held 0 → data_out stays 8'h11, overrun pulses once at the second ts+1. Repeat with ready = 1 exactly at the second ts → data_out becomes 8'h22 and valid stays 1 continuously.
- Three back-to-back frames 8'h00, 8'hFF, 8'h7E (no idle gap), ready = 1 → three valid pulses carrying those values, no error pulses.
- rst asserted mid-DATA of 8'hC3 → all outputs 0 immediately (asynchronous), rx_busy = 0. After release, frame 8'h96 → received as 8'h96.
